// File: rtl/kronos_xif_coproc_frontend.sv
// Coprocessor-side CORE-V-XIF frontend: issue/commit/result termination, an ID-ordered queue and a small ALU.
// Optional protocol checker (sticky err_o) is enabled by defining KRONOS_XIF_ERR_CHECK_EN.
module kronos_xif_coproc_frontend #(
  parameter int unsigned X_ID_WIDTH    = 4,
  parameter int unsigned X_RFR_WIDTH   = 32,
  parameter int unsigned DEPTH         = 4,
  parameter logic [6:0]  ACCEPT_OPCODE = 7'b0001011
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [31:0]            issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]  issue_id_i,
  input  logic [X_RFR_WIDTH-1:0] issue_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] issue_rs2_i,
  input  logic [1:0]             issue_rs_valid_i,
  output logic                   issue_accept_o,
  output logic                   issue_writeback_o,
  input  logic                   commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  input  logic                   commit_kill_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [X_ID_WIDTH-1:0]  result_id_o,
  output logic [X_RFR_WIDTH-1:0] result_data_o,
  output logic [4:0]             result_rd_o,
  output logic                   result_we_o,
  output logic                   result_exc_o
`ifdef KRONOS_XIF_ERR_CHECK_EN
  ,
  output logic                   err_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  function automatic logic [X_RFR_WIDTH-1:0] alu(input logic [2:0] f,
                                                 input logic [X_RFR_WIDTH-1:0] a,
                                                 input logic [X_RFR_WIDTH-1:0] b);
    logic signed [X_RFR_WIDTH-1:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a ^ b;
      3'b011:  alu = a & b;
      3'b100:  alu = a | b;
      3'b101:  alu = a << b[4:0];
      3'b110:  alu = a >> b[4:0];
      default: alu = {{(X_RFR_WIDTH-1){1'b0}}, (sa < sb)};
    endcase
  endfunction

  logic                   q_vld_q  [DEPTH];
  logic                   q_cmt_q  [DEPTH];
  logic                   q_kill_q [DEPTH];
  logic [X_ID_WIDTH-1:0]  q_id_q   [DEPTH];
  logic [2:0]             q_f3_q   [DEPTH];
  logic [4:0]             q_rd_q   [DEPTH];
  logic [X_RFR_WIDTH-1:0] q_rs1_q  [DEPTH];
  logic [X_RFR_WIDTH-1:0] q_rs2_q  [DEPTH];
  logic                   q_vld_d  [DEPTH];
  logic                   q_cmt_d  [DEPTH];
  logic                   q_kill_d [DEPTH];
  logic [X_ID_WIDTH-1:0]  q_id_d   [DEPTH];
  logic [2:0]             q_f3_d   [DEPTH];
  logic [4:0]             q_rd_d   [DEPTH];
  logic [X_RFR_WIDTH-1:0] q_rs1_d  [DEPTH];
  logic [X_RFR_WIDTH-1:0] q_rs2_d  [DEPTH];

  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   res_vld_q, res_vld_d;
  logic [X_ID_WIDTH-1:0]  res_id_q, res_id_d;
  logic [X_RFR_WIDTH-1:0] res_data_q, res_data_d;
  logic [4:0]             res_rd_q, res_rd_d;

  logic accept_rule, push, pop, load, head_match, head_ok, head_kill;
  logic unused_instr;

  assign unused_instr      = ^issue_instr_i[31:15];
  assign accept_rule       = (issue_instr_i[6:0] == ACCEPT_OPCODE) && (&issue_rs_valid_i);
  assign issue_ready_o     = (count_q != CNT_W'(DEPTH));
  assign issue_accept_o    = issue_valid_i && accept_rule;
  assign issue_writeback_o = issue_valid_i && accept_rule;
  assign push              = issue_valid_i && issue_ready_o && accept_rule;

  // Head decision sees this cycle's commit directly so a commit on the head costs no extra cycle.
  assign head_match = commit_valid_i && q_vld_q[head_q] && (q_id_q[head_q] == commit_id_i);
  assign head_ok    = q_vld_q[head_q] && (q_cmt_q[head_q] || (head_match && !commit_kill_i));
  assign head_kill  = q_vld_q[head_q] && !head_ok &&
                      (q_kill_q[head_q] || (head_match && commit_kill_i));
  assign load       = head_ok && (!res_vld_q || result_ready_i);
  assign pop        = load || head_kill;

`ifdef KRONOS_XIF_ERR_CHECK_EN
  logic err_q, err_d, commit_hit, commit_dup, id_dup;
  assign err_o = err_q;
`endif

  always_comb begin
    q_vld_d    = q_vld_q;
    q_cmt_d    = q_cmt_q;
    q_kill_d   = q_kill_q;
    q_id_d     = q_id_q;
    q_f3_d     = q_f3_q;
    q_rd_d     = q_rd_q;
    q_rs1_d    = q_rs1_q;
    q_rs2_d    = q_rs2_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    res_vld_d  = res_vld_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
`ifdef KRONOS_XIF_ERR_CHECK_EN
    commit_hit = 1'b0;
    commit_dup = 1'b0;
    id_dup     = 1'b0;
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && q_vld_q[i] && (q_id_q[i] == commit_id_i)) begin
`ifdef KRONOS_XIF_ERR_CHECK_EN
        commit_hit = 1'b1;
        if (q_cmt_q[i] || q_kill_q[i]) commit_dup = 1'b1;
`endif
        if (commit_kill_i) q_kill_d[i] = 1'b1;
        else               q_cmt_d[i]  = 1'b1;
      end
`ifdef KRONOS_XIF_ERR_CHECK_EN
      if (q_vld_q[i] && (q_id_q[i] == issue_id_i)) id_dup = 1'b1;
`endif
    end

    if (load) begin
      res_vld_d  = 1'b1;
      res_id_d   = q_id_q[head_q];
      res_rd_d   = q_rd_q[head_q];
      res_data_d = alu(q_f3_q[head_q], q_rs1_q[head_q], q_rs2_q[head_q]);
    end else if (result_ready_i) begin
      res_vld_d  = 1'b0;
    end

    if (pop) begin
      q_vld_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    // Tail slot is never the popped head: they coincide only when empty (no pop) or full (no push).
    if (push) begin
      q_vld_d[tail_q]  = 1'b1;
      q_cmt_d[tail_q]  = 1'b0;
      q_kill_d[tail_q] = 1'b0;
      q_id_d[tail_q]   = issue_id_i;
      q_f3_d[tail_q]   = issue_instr_i[14:12];
      q_rd_d[tail_q]   = issue_instr_i[11:7];
      q_rs1_d[tail_q]  = issue_rs1_i;
      q_rs2_d[tail_q]  = issue_rs2_i;
      tail_d           = tail_q + PTR_W'(1);
    end

`ifdef KRONOS_XIF_ERR_CHECK_EN
    err_d = err_q || (commit_valid_i && !commit_hit) || commit_dup || (push && id_dup);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_vld_q[i]  <= 1'b0;
        q_cmt_q[i]  <= 1'b0;
        q_kill_q[i] <= 1'b0;
        q_id_q[i]   <= '0;
        q_f3_q[i]   <= '0;
        q_rd_q[i]   <= '0;
        q_rs1_q[i]  <= '0;
        q_rs2_q[i]  <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      res_vld_q  <= 1'b0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
`ifdef KRONOS_XIF_ERR_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      q_vld_q    <= q_vld_d;
      q_cmt_q    <= q_cmt_d;
      q_kill_q   <= q_kill_d;
      q_id_q     <= q_id_d;
      q_f3_q     <= q_f3_d;
      q_rd_q     <= q_rd_d;
      q_rs1_q    <= q_rs1_d;
      q_rs2_q    <= q_rs2_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      res_vld_q  <= res_vld_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
`ifdef KRONOS_XIF_ERR_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign result_valid_o = res_vld_q;
  assign result_id_o    = res_id_q;
  assign result_data_o  = res_data_q;
  assign result_rd_o    = res_rd_q;
  assign result_we_o    = res_vld_q;
  assign result_exc_o   = 1'b0;

endmodule

// File: tb/tb_kronos_xif_coproc_frontend.sv
// Directed bench for kronos_xif_coproc_frontend: issue/accept, commit ordering, kill, result hold, ALU corners, reset.
module tb_kronos_xif_coproc_frontend;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [3:0]  issue_id_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic [31:0] issue_rs2_i = '0;
  logic [1:0]  issue_rs_valid_i = '0;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o, result_exc_o;
`ifdef KRONOS_XIF_ERR_CHECK_EN
  logic        err_o;
`endif

  int errors = 0;
  int checks = 0;

  kronos_xif_coproc_frontend dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_exc_o(result_exc_o)
`ifdef KRONOS_XIF_ERR_CHECK_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, 7'b0001011};
  endfunction

  task automatic issue(input logic [31:0] instr, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid_i = 1'b1; issue_instr_i = instr; issue_id_i = id;
    issue_rs1_i = a; issue_rs2_i = b; issue_rs_valid_i = 2'b11;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_rs_valid_i = 2'b00; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; idle(); result_ready_i = 1'b0;
    step(); step();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", issue_ready_o); end
    checks++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0) begin errors++; $display("FAIL rst_accept: got %b%b want 00", issue_accept_o, issue_writeback_o); end
    checks++; if (result_valid_o !== 1'b0 || result_we_o !== 1'b0 || result_exc_o !== 1'b0) begin errors++; $display("FAIL rst_res_ctrl: got %b%b%b want 000", result_valid_o, result_we_o, result_exc_o); end
    checks++; if (result_id_o !== 4'd0 || result_data_o !== 32'd0 || result_rd_o !== 5'd0) begin errors++; $display("FAIL rst_res_data: id %0d data %h rd %0d want 0", result_id_o, result_data_o, result_rd_o); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_add();
    issue(mk(3'b000, 5'd10), 4'd3, 32'd5, 32'd7);
    #1;
    checks++; if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b1) begin errors++; $display("FAIL add_accept: got %b%b want 11", issue_accept_o, issue_writeback_o); end
    step();
    idle(); commit(4'd3, 1'b0);
    #1;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL add_early: got %b want 0", result_valid_o); end
    step();
    idle();
    checks++; if (result_valid_o !== 1'b1 || result_id_o !== 4'd3 || result_data_o !== 32'd12 || result_rd_o !== 5'd10 || result_we_o !== 1'b1 || result_exc_o !== 1'b0)
      begin errors++; $display("FAIL add_result: v%b id %0d data %0d rd %0d we %b exc %b want v1 id 3 data 12 rd 10 we 1 exc 0", result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o); end
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", result_valid_o); end
  endtask

  task automatic test_reject();
    issue({17'b0, 3'b000, 5'd1, 7'b0110011}, 4'd2, 32'd1, 32'd1);
    #1;
    checks++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0) begin errors++; $display("FAIL rej_accept: got %b%b want 00", issue_accept_o, issue_writeback_o); end
    step();
    idle(); commit(4'd2, 1'b0); result_ready_i = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rej_noresult: cycle %0d got %b want 0", i, result_valid_o); end
      step();
    end
    result_ready_i = 1'b0;
  endtask

  task automatic test_full_order();
    logic [3:0] id;
    result_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id = 4'(i);
      issue(mk(3'b000, 5'(i)), id, 32'(i * 10), 32'd1);
      #1;
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_pre%0d: got %b want 1", i, issue_ready_o); end
      step();
    end
    idle();
    #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", issue_ready_o); end
    for (int i = 4; i >= 2; i--) begin
      id = 4'(i);
      commit(id, 1'b0);
      step();
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL full_wait%0d: got %b want 0", i, result_valid_o); end
    end
    commit(4'd1, 1'b0);
    step();
    idle();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (result_valid_o !== 1'b1 || result_id_o !== 4'(i) || result_data_o !== 32'(i * 10 + 1) || result_rd_o !== 5'(i))
        begin errors++; $display("FAIL full_order%0d: v%b id %0d data %0d rd %0d want v1 id %0d data %0d rd %0d", i, result_valid_o, result_id_o, result_data_o, result_rd_o, i, i * 10 + 1, i); end
      step();
    end
    checks++; if (result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_drain: v%b ready %b want v0 ready 1", result_valid_o, issue_ready_o); end
    result_ready_i = 1'b0;
  endtask

  task automatic test_kill_hold();
    result_ready_i = 1'b0;
    issue(mk(3'b010, 5'd7), 4'd5, 32'h0F0, 32'h0FF);
    step();
    issue(mk(3'b100, 5'd8), 4'd6, 32'h100, 32'h001);
    step();
    idle(); commit(4'd5, 1'b1);
    step();
    idle();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL kill_noresult: got %b want 0", result_valid_o); end
    commit(4'd6, 1'b0);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) result_ready_i = 1'b1;
      checks++; if (result_valid_o !== 1'b1 || result_id_o !== 4'd6 || result_data_o !== 32'h101 || result_rd_o !== 5'd8)
        begin errors++; $display("FAIL kill_hold%0d: v%b id %0d data %h rd %0d want v1 id 6 data 101 rd 8", i, result_valid_o, result_id_o, result_data_o, result_rd_o); end
      step();
    end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL kill_single: got %b want 0", result_valid_o); end
    result_ready_i = 1'b0;
  endtask

  task automatic test_alu_corners();
    issue(mk(3'b001, 5'd3), 4'd2, 32'd0, 32'd1);
    step();
    issue(mk(3'b111, 5'd4), 4'd4, 32'h8000_0000, 32'd1);
    commit(4'd2, 1'b0);
    step();
    idle();
    checks++; if (result_valid_o !== 1'b1 || result_id_o !== 4'd2 || result_data_o !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL sub_wrap: v%b id %0d data %h want v1 id 2 data ffffffff", result_valid_o, result_id_o, result_data_o); end
    commit(4'd4, 1'b0); result_ready_i = 1'b1;
    step();
    idle();
    checks++; if (result_valid_o !== 1'b1 || result_id_o !== 4'd4 || result_data_o !== 32'd1 || result_rd_o !== 5'd4)
      begin errors++; $display("FAIL slt_signed: v%b id %0d data %h rd %0d want v1 id 4 data 1 rd 4", result_valid_o, result_id_o, result_data_o, result_rd_o); end
    issue(mk(3'b101, 5'd9), 4'd1, 32'd3, 32'h21);
    step();
    idle(); commit(4'd1, 1'b0);
    step();
    idle();
    checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'd6) begin errors++; $display("FAIL sll_mask: v%b data %h want v1 data 6", result_valid_o, result_data_o); end
    step();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    result_ready_i = 1'b0;
    issue(mk(3'b000, 5'd1), 4'd7, 32'd1, 32'd1);
    step();
    issue(mk(3'b000, 5'd2), 4'd8, 32'd2, 32'd2);
    commit(4'd7, 1'b0);
    step();
    idle(); commit(4'd8, 1'b0);
    step();
    idle();
    checks++; if (result_valid_o !== 1'b1 || result_id_o !== 4'd7) begin errors++; $display("FAIL mid_pending: v%b id %0d want v1 id 7", result_valid_o, result_id_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mid_async: got %b want 0", result_valid_o); end
    step();
    rst_ni = 1'b1; result_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin errors++; $display("FAIL mid_discard%0d: v%b ready %b want v0 ready 1", i, result_valid_o, issue_ready_o); end
    end
    result_ready_i = 1'b0;
  endtask

`ifdef KRONOS_XIF_ERR_CHECK_EN
  task automatic test_err();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clean: got %b want 0", err_o); end
    commit(4'd9, 1'b0);
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err_o); end
    step();
    idle();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_o); end
    step(); step();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_o); end
    step();
    rst_ni = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_reject();
    test_full_order();
    test_kill_hold();
    test_alu_corners();
    test_reset_mid();
`ifdef KRONOS_XIF_ERR_CHECK_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
